alu_seq_unit: RTL

//  Parametrised sequential successor to the 32-bit combinational ALU. Adds valid/ready handshakes on operand
//  and result sides, a registered result/flag stage and iterative multiply/divide/remainder. Sits between
//  the decode/issue stage and writeback; one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_iter_muldiv.sv | 74 +++++++
 rtl/alu_seq_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag positions
// for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOTA  = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_SRA   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_DIV   = 4'd11;
   localparam logic [3:0] OP_REM   = 4'd12;
   localparam logic [3:0] OP_PASSB = 4'd13;

   localparam int N_OPS = 14;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   localparam int F_E = 4;
   localparam int F_V = 3;
   localparam int F_N = 2;
   localparam int F_Z = 1;
   localparam int F_B = 0;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider.
// done and lo/hi present the final iteration combinationally.
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);

   logic             busy;
   logic             mode_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shf;
   logic [WIDTH+1:0] dif;
   logic [WIDTH-1:0] nhi;
   logic [WIDTH-1:0] nlo;

   assign done = busy && (cnt == CW'(WIDTH - 1));
   assign lo   = nlo;
   assign hi   = nhi;

   // one multiply or divide step on the {hi,lo} pair
   always_comb begin
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      shf = {acc_hi, acc_lo[WIDTH-1]};
      dif = {1'b0, shf} - {2'b00, opnd};
      if (mode_q) begin
         nhi = dif[WIDTH+1] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
         nlo = {acc_lo[WIDTH-2:0], ~dif[WIDTH+1]};
      end else begin
         nhi = sum[WIDTH:1];
         nlo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // load operands on start, then iterate WIDTH times
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         mode_q <= 1'b0;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         mode_q <= mode;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= mode ? a : b;
         opnd   <= mode ? b : a;
      end else if (busy) begin
         acc_hi <= nhi;
         acc_lo <= nlo;
         cnt    <= cnt + 1'b1;
         if (done)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes,
// registered results and iterative mul/div/rem.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry,
   output logic [4:0]       flags
);

   localparam int SW = $clog2(WIDTH);
   localparam int M  = WIDTH - 1;

   state_t           state;
   logic             accept;
   logic             rem_q;
   logic [3:0]       op;
   logic             legal;
   logic [SW-1:0]    sh;
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] r1;
   logic             c1;
   logic             v1;
   logic             e1;
   logic             is_mul;
   logic             is_div;
   logic [4:0]       f1;
   logic             md_done;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] rm;
   logic             vm;
   logic [4:0]       fm;

   assign in_ready = (state == IDLE) ||
                     (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   // single-cycle result and classification of the op
   always_comb begin
      op     = opcode[3:0];
      legal  = opcode < OPW'(N_OPS);
      sh     = b[SW-1:0];
      ext    = '0;
      r1     = '0;
      c1     = 1'b0;
      v1     = 1'b0;
      e1     = !legal;
      is_mul = 1'b0;
      is_div = 1'b0;
      if (legal) begin
         unique case (op)
            OP_ADD: begin
               ext = {1'b0, a} + {1'b0, b};
               r1  = ext[WIDTH-1:0];
               c1  = ext[WIDTH];
               v1  = (a[M] == b[M]) && (r1[M] != a[M]);
            end
            OP_SUB: begin
               ext = {1'b0, a} - {1'b0, b};
               r1  = ext[WIDTH-1:0];
               c1  = ext[WIDTH];
               v1  = (a[M] != b[M]) && (r1[M] != a[M]);
            end
            OP_AND:  r1 = a & b;
            OP_OR:   r1 = a | b;
            OP_XOR:  r1 = a ^ b;
            OP_NOTA: r1 = ~a;
            OP_SHL: begin
               ext = {1'b0, a} << sh;
               r1  = ext[WIDTH-1:0];
               c1  = ext[WIDTH];
            end
            OP_SHR: begin
               ext = {a, 1'b0} >> sh;
               r1  = ext[WIDTH:1];
               c1  = ext[0];
            end
            OP_SRA: begin
               ext = $signed({a, 1'b0}) >>> sh;
               r1  = ext[WIDTH:1];
               c1  = ext[0];
            end
            OP_SLT:  r1 = WIDTH'($signed(a) < $signed(b));
            OP_MUL:  is_mul = 1'b1;
            OP_DIV, OP_REM: begin
               if (b == '0) begin
                  e1 = 1'b1;
                  r1 = (op == OP_DIV) ? '1 : a;
               end else begin
                  is_div = 1'b1;
               end
            end
            OP_PASSB: r1 = b;
            default:  r1 = '0;
         endcase
      end
      f1 = {e1, v1, r1[M], r1 == '0, 1'b0};
   end

   alu_iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_md (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && (is_mul || is_div)),
      .mode  (is_div),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
   );

   // result and flags of a finishing iteration
   always_comb begin
      rm = rem_q ? md_hi : md_lo;
      vm = (state == MUL) && (md_hi != '0);
      fm = {1'b0, vm, rm[M], rm == '0, 1'b0};
   end

   // control FSM with registered result stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         alu_out   <= '0;
         carry     <= 1'b0;
         flags     <= '0;
         out_valid <= 1'b0;
         rem_q     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  rem_q <= (op == OP_REM);
                  if (is_mul || is_div) begin
                     state      <= is_mul ? MUL : DIV;
                     out_valid  <= 1'b0;
                     alu_out    <= '0;
                     carry      <= 1'b0;
                     flags      <= '0;
                     flags[F_B] <= 1'b1;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     alu_out   <= r1;
                     carry     <= c1;
                     flags     <= f1;
                  end
               end else if (state == DONE && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            MUL, DIV: begin
               if (md_done) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  alu_out   <= rm;
                  carry     <= 1'b0;
                  flags     <= fm;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
